// File: rtl/fmsynth_pkg.sv
// Shared types and constants for the fmsynth command sequencer.
// The command entry packs {delay, addr, data} into 56 bits, with the delay in the MSBs.
package fmsynth_pkg;

    localparam int ENTRY_W = 56;

    localparam logic [7:0] FM_CH_BASE = 8'h60;
    localparam logic [7:0] FM_OP_BASE = 8'h80;

    typedef struct packed {
        logic [15:0] delay;
        logic [7:0]  addr;
        logic [31:0] data;
    } cmd_entry_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DELAY = 2'd1,
        ST_WRITE = 2'd2
    } seq_state_t;

endpackage

// File: rtl/fmsynth_cmd_fifo.sv
// Show-ahead command FIFO with a synchronous clear and registered occupancy.
// A push while full is dropped, even when a pop happens in the same cycle.
module fmsynth_cmd_fifo #(
    parameter int WIDTH = 56,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     clear,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // NOTE: the storage array has no reset; only the pointers and count define which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push && !clear) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)      count <= count + (AW+1)'(1);
            else if (!do_push && do_pop) count <= count - (AW+1)'(1);
        end
    end

    assign rdata = mem[rd_ptr];
    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign level = count;

endmodule

// File: rtl/fmsynth_sequencer.sv
// Timed register-write sequencer: replays queued {delay, addr, data} commands
// onto the fmsynth register bus after a per-command tick delay.
module fmsynth_sequencer
    import fmsynth_pkg::*;
#(
    parameter int DEPTH    = 16,
    parameter int TICK_DIV = 28636
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     cmd_wr,
    input  logic [15:0]              cmd_delay,
    input  logic [7:0]               cmd_addr,
    input  logic [31:0]              cmd_data,
    output logic                     cmd_full,
    output logic [$clog2(DEPTH):0]   cmd_level,
    output logic                     overflow,
    input  logic                     flush,
    input  logic                     pause,
    output logic                     busy,
    output logic [7:0]               fm_addr,
    output logic [31:0]              fm_wrdata,
    output logic                     fm_wren,
    input  logic                     fm_wait
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    seq_state_t  state, state_next;
    cmd_entry_t  push_entry, head, hold;
    logic [15:0] delay_cnt;
    logic [PW-1:0] presc;
    logic        flush_pend;
    logic        fifo_push, fifo_pop, fifo_clear, fifo_empty;
    logic        load_cmd, tick;

    // A push in the same cycle as flush is discarded.
    assign fifo_push  = cmd_wr && !flush;
    assign push_entry = '{delay: cmd_delay, addr: cmd_addr, data: cmd_data};

    fmsynth_cmd_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (fifo_clear),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .wdata   (push_entry),
        .rdata   (head),
        .full    (cmd_full),
        .empty   (fifo_empty),
        .level   (cmd_level)
    );

    // NOTE: every signal written here gets a default first so no latch can be inferred.
    always_comb begin
        state_next = state;
        fifo_pop   = 1'b0;
        fifo_clear = 1'b0;
        load_cmd   = 1'b0;
        tick       = 1'b0;
        fm_wren    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (flush) begin
                    fifo_clear = 1'b1;
                end else if (!fifo_empty && !pause) begin
                    fifo_pop   = 1'b1;
                    load_cmd   = 1'b1;
                    state_next = (head.delay == 16'd0) ? ST_WRITE : ST_DELAY;
                end
            end
            ST_DELAY: begin
                if (flush) begin
                    fifo_clear = 1'b1;
                    state_next = ST_IDLE;
                end else if (!pause && presc == PW'(TICK_DIV - 1)) begin
                    tick = 1'b1;
                    if (delay_cnt == 16'd1) state_next = ST_WRITE;
                end
            end
            ST_WRITE: begin
                fm_wren = 1'b1;
                if (!fm_wait) begin
                    state_next = ST_IDLE;
                    // A flush seen during the write takes effect as the write completes.
                    fifo_clear = flush || flush_pend;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            hold       <= '0;
            delay_cnt  <= '0;
            presc      <= '0;
            flush_pend <= 1'b0;
            overflow   <= 1'b0;
            fm_addr    <= '0;
            fm_wrdata  <= '0;
        end else begin
            state <= state_next;

            if (load_cmd) begin
                hold      <= head;
                delay_cnt <= head.delay;
                presc     <= '0;
            end else if (state == ST_DELAY && !pause && !flush) begin
                if (tick) begin
                    presc     <= '0;
                    delay_cnt <= delay_cnt - 16'd1;
                end else begin
                    presc <= presc + PW'(1);
                end
            end

            // Bus address/data change only on entry to WRITE and hold otherwise.
            if (state_next == ST_WRITE && state != ST_WRITE) begin
                fm_addr   <= (state == ST_IDLE) ? head.addr : hold.addr;
                fm_wrdata <= (state == ST_IDLE) ? head.data : hold.data;
            end

            if (fifo_clear)                      flush_pend <= 1'b0;
            else if (state == ST_WRITE && flush) flush_pend <= 1'b1;

            if (fifo_clear)                      overflow <= 1'b0;
            else if (fifo_push && cmd_full)      overflow <= 1'b1;
        end
    end

    assign busy = (state != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_fmsynth_sequencer.sv
// Self-checking bench for fmsynth_sequencer: a bus monitor logs every accepted
// write with its edge index, and each scenario compares that log against timing from the command rules.
module tb_fmsynth_sequencer;
    import fmsynth_pkg::*;

    localparam int DEPTH    = 4;
    localparam int TICK_DIV = 4;
    localparam int LW       = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          cmd_wr = 1'b0;
    logic [15:0]   cmd_delay = '0;
    logic [7:0]    cmd_addr = '0;
    logic [31:0]   cmd_data = '0;
    logic          cmd_full;
    logic [LW-1:0] cmd_level;
    logic          overflow;
    logic          flush = 1'b0;
    logic          pause = 1'b0;
    logic          busy;
    logic [7:0]    fm_addr;
    logic [31:0]   fm_wrdata;
    logic          fm_wren;
    logic          fm_wait = 1'b0;

    fmsynth_sequencer #(.DEPTH(DEPTH), .TICK_DIV(TICK_DIV)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cmd_wr    (cmd_wr),
        .cmd_delay (cmd_delay),
        .cmd_addr  (cmd_addr),
        .cmd_data  (cmd_data),
        .cmd_full  (cmd_full),
        .cmd_level (cmd_level),
        .overflow  (overflow),
        .flush     (flush),
        .pause     (pause),
        .busy      (busy),
        .fm_addr   (fm_addr),
        .fm_wrdata (fm_wrdata),
        .fm_wren   (fm_wren),
        .fm_wait   (fm_wait)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    int          obs_edge[$];
    logic [7:0]  obs_addr[$];
    logic [31:0] obs_data[$];
    int          wren_cycles = 0;
    int          unstable = 0;
    logic        prev_wren = 1'b0;
    logic [7:0]  prev_addr = '0;
    logic [31:0] prev_data = '0;

    // Mid-cycle bus monitor; an accepted write lands on the next rising edge.
    always @(negedge clk) begin
        if (fm_wren) begin
            wren_cycles++;
            if (prev_wren && (fm_addr !== prev_addr || fm_wrdata !== prev_data)) unstable++;
            if (!fm_wait) begin
                obs_edge.push_back(cyc + 1);
                obs_addr.push_back(fm_addr);
                obs_data.push_back(fm_wrdata);
            end
        end
        prev_wren = fm_wren;
        prev_addr = fm_addr;
        prev_data = fm_wrdata;
    end

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_obs();
        obs_edge.delete();
        obs_addr.delete();
        obs_data.delete();
        wren_cycles = 0;
        unstable = 0;
    endtask

    task automatic push(input logic [15:0] d, input logic [7:0] a, input logic [31:0] dat, output int edge_idx);
        cmd_wr    = 1'b1;
        cmd_delay = d;
        cmd_addr  = a;
        cmd_data  = dat;
        step();
        edge_idx  = cyc;
        cmd_wr    = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        checks++; if (fm_wren !== 1'b0) begin errors++; $display("FAIL %s fm_wren: got %b want 0", tag, fm_wren); end
        checks++; if (fm_addr !== 8'h00) begin errors++; $display("FAIL %s fm_addr: got %h want 00", tag, fm_addr); end
        checks++; if (fm_wrdata !== 32'h0) begin errors++; $display("FAIL %s fm_wrdata: got %h want 0", tag, fm_wrdata); end
        checks++; if (cmd_full !== 1'b0) begin errors++; $display("FAIL %s cmd_full: got %b want 0", tag, cmd_full); end
        checks++; if (cmd_level !== '0) begin errors++; $display("FAIL %s cmd_level: got %0d want 0", tag, cmd_level); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL %s overflow: got %b want 0", tag, overflow); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL %s busy: got %b want 0", tag, busy); end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        step(3);
        check_idle_outputs("reset");
        reset_n = 1'b1;
        step(2);
    endtask

    task automatic test_single();
        int e;
        clear_obs();
        push(16'd0, FM_OP_BASE, 32'h0015_0F07, e);
        step(6);
        checks++; if (obs_edge.size() != 1) begin errors++; $display("FAIL single count: got %0d want 1", obs_edge.size()); end
        else begin
            checks++; if (obs_edge[0] != e + 2) begin errors++; $display("FAIL single edge: got %0d want %0d", obs_edge[0], e + 2); end
            checks++; if (obs_addr[0] !== 8'h80) begin errors++; $display("FAIL single addr: got %h want 80", obs_addr[0]); end
            checks++; if (obs_data[0] !== 32'h0015_0F07) begin errors++; $display("FAIL single data: got %h want 00150f07", obs_data[0]); end
        end
        checks++; if (wren_cycles != 1) begin errors++; $display("FAIL single wren_cycles: got %0d want 1", wren_cycles); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single busy: got %b want 0", busy); end
    endtask

    task automatic test_delay();
        int e0, e1, pop0;
        logic [31:0] x, y;
        clear_obs();
        x = $urandom;
        y = $urandom;
        push(16'd3, FM_CH_BASE, x, e0);
        push(16'd0, FM_CH_BASE + 8'd1, y, e1);
        pop0 = e0 + 1;
        step(30);
        checks++; if (obs_edge.size() != 2) begin errors++; $display("FAIL delay count: got %0d want 2", obs_edge.size()); end
        else begin
            checks++; if (obs_edge[0] != pop0 + 13) begin errors++; $display("FAIL delay first edge: got %0d want %0d", obs_edge[0], pop0 + 13); end
            checks++; if (obs_edge[1] != obs_edge[0] + 2) begin errors++; $display("FAIL delay second edge: got %0d want %0d", obs_edge[1], obs_edge[0] + 2); end
            checks++; if (obs_addr[0] !== 8'h60 || obs_data[0] !== x) begin errors++; $display("FAIL delay first write: got %h/%h want 60/%h", obs_addr[0], obs_data[0], x); end
            checks++; if (obs_addr[1] !== 8'h61 || obs_data[1] !== y) begin errors++; $display("FAIL delay second write: got %h/%h want 61/%h", obs_addr[1], obs_data[1], y); end
        end
    endtask

    // Random back-to-back commands; accept edges predicted from push edges and delays.
    task automatic test_back_to_back();
        for (int round = 0; round < 3; round++) begin
            int          e[4];
            int          exp_edge[4];
            logic [15:0] d[4];
            logic [7:0]  a[4];
            logic [31:0] v[4];
            int          last_acc;
            clear_obs();
            for (int i = 0; i < 4; i++) begin
                d[i] = 16'($urandom_range(0, 3));
                a[i] = 8'($urandom);
                v[i] = $urandom;
                push(d[i], a[i], v[i], e[i]);
            end
            last_acc = -100;
            for (int i = 0; i < 4; i++) begin
                int pop_edge;
                pop_edge = (e[i] + 1 > last_acc + 1) ? e[i] + 1 : last_acc + 1;
                exp_edge[i] = pop_edge + int'(d[i]) * TICK_DIV + 1;
                last_acc = exp_edge[i];
            end
            step(80);
            checks++;
            if (obs_edge.size() != 4) begin
                errors++; $display("FAIL b2b[%0d] count: got %0d want 4", round, obs_edge.size());
            end else begin
                for (int i = 0; i < 4; i++) begin
                    checks++;
                    if (obs_edge[i] != exp_edge[i] || obs_addr[i] !== a[i] || obs_data[i] !== v[i]) begin
                        errors++;
                        $display("FAIL b2b[%0d][%0d]: got edge %0d %h/%h want edge %0d %h/%h",
                                 round, i, obs_edge[i], obs_addr[i], obs_data[i], exp_edge[i], a[i], v[i]);
                    end
                end
            end
        end
    endtask

    task automatic test_wait();
        int e;
        logic [31:0] v;
        clear_obs();
        v = $urandom;
        fm_wait = 1'b1;
        push(16'd0, 8'h42, v, e);
        step(6);
        fm_wait = 1'b0;
        step(6);
        checks++; if (obs_edge.size() != 1) begin errors++; $display("FAIL wait count: got %0d want 1", obs_edge.size()); end
        else begin
            checks++; if (obs_edge[0] != e + 7) begin errors++; $display("FAIL wait edge: got %0d want %0d", obs_edge[0], e + 7); end
            checks++; if (obs_addr[0] !== 8'h42 || obs_data[0] !== v) begin errors++; $display("FAIL wait write: got %h/%h want 42/%h", obs_addr[0], obs_data[0], v); end
        end
        checks++; if (wren_cycles != 6) begin errors++; $display("FAIL wait wren_cycles: got %0d want 6", wren_cycles); end
        checks++; if (unstable != 0) begin errors++; $display("FAIL wait stability: got %0d changes want 0", unstable); end
    endtask

    task automatic test_overflow();
        logic [7:0]  a[DEPTH+1];
        logic [31:0] v[DEPTH+1];
        int e;
        clear_obs();
        pause = 1'b1;
        for (int i = 0; i <= DEPTH; i++) begin
            a[i] = 8'($urandom);
            v[i] = $urandom;
            push(16'($urandom_range(0, 2)), a[i], v[i], e);
        end
        checks++; if (cmd_full !== 1'b1) begin errors++; $display("FAIL ovf cmd_full: got %b want 1", cmd_full); end
        checks++; if (cmd_level !== LW'(DEPTH)) begin errors++; $display("FAIL ovf cmd_level: got %0d want %0d", cmd_level, DEPTH); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf overflow: got %b want 1", overflow); end
        step(10);
        checks++; if (obs_edge.size() != 0) begin errors++; $display("FAIL ovf paused writes: got %0d want 0", obs_edge.size()); end
        pause = 1'b0;
        step(DEPTH * (2 * TICK_DIV + 2) + 20);
        checks++;
        if (obs_edge.size() != DEPTH) begin
            errors++; $display("FAIL ovf write count: got %0d want %0d", obs_edge.size(), DEPTH);
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                checks++;
                if (obs_addr[i] !== a[i] || obs_data[i] !== v[i]) begin
                    errors++; $display("FAIL ovf order[%0d]: got %h/%h want %h/%h", i, obs_addr[i], obs_data[i], a[i], v[i]);
                end
            end
        end
    endtask

    task automatic test_flush();
        int e;
        logic [31:0] va;
        // Flush while the head command is counting down; overflow is still set from the previous scenario.
        clear_obs();
        push(16'd8, 8'h11, $urandom, e);
        push(16'd0, 8'h12, $urandom, e);
        push(16'd0, 8'h13, $urandom, e);
        step(3);
        flush = 1'b1;
        step();
        flush = 1'b0;
        checks++; if (cmd_level !== '0) begin errors++; $display("FAIL flush_delay level: got %0d want 0", cmd_level); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL flush_delay overflow: got %b want 0", overflow); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_delay busy: got %b want 0", busy); end
        step(50);
        checks++; if (obs_edge.size() != 0) begin errors++; $display("FAIL flush_delay writes: got %0d want 0", obs_edge.size()); end

        // Flush while a write is stalled: that write completes, the queued one is dropped.
        clear_obs();
        va = $urandom;
        fm_wait = 1'b1;
        push(16'd0, 8'h21, va, e);
        push(16'd0, 8'h22, $urandom, e);
        flush = 1'b1;
        step();
        flush = 1'b0;
        step();
        fm_wait = 1'b0;
        step(30);
        checks++; if (obs_edge.size() != 1) begin errors++; $display("FAIL flush_write count: got %0d want 1", obs_edge.size()); end
        else begin
            checks++; if (obs_addr[0] !== 8'h21 || obs_data[0] !== va) begin errors++; $display("FAIL flush_write data: got %h/%h want 21/%h", obs_addr[0], obs_data[0], va); end
        end
        checks++; if (cmd_level !== '0) begin errors++; $display("FAIL flush_write level: got %0d want 0", cmd_level); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_write busy: got %b want 0", busy); end
    endtask

    task automatic test_reset_mid_delay();
        int e;
        clear_obs();
        push(16'd10, 8'h31, $urandom, e);
        push(16'd0, 8'h32, $urandom, e);
        push(16'd0, 8'h33, $urandom, e);
        push(16'd0, 8'h34, $urandom, e);
        step(2);
        checks++; if (cmd_level !== LW'(3)) begin errors++; $display("FAIL rst_mid level before: got %0d want 3", cmd_level); end
        reset_n = 1'b0;
        #1;
        check_idle_outputs("rst_mid");
        step(2);
        reset_n = 1'b1;
        step(80);
        checks++; if (obs_edge.size() != 0) begin errors++; $display("FAIL rst_mid writes: got %0d want 0", obs_edge.size()); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid busy after: got %b want 0", busy); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_delay();
        test_back_to_back();
        test_wait();
        test_overflow();
        test_flush();
        test_reset_mid_delay();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
